icache_refill: RTL and testbench
================================

Name: icache_refill

Overview:
Miss/refill engine that writes the instruction cache: it is the writer-side counterpart of the icache CAM write port.
- On a fetch miss it issues one line-aligned burst read on the memory bus.
- It writes each returned word, with its tag and flags, into the CAM.
- It forwards the missed (critical) word to fetch as it passes.
- It signals completion or bus error back to fetch.

Parameters:
LINE_WORDS, 4, words per refill line; power of two, 2..16.
OFF_W, $clog2(LINE_WORDS), width of the word offset within a line (derived, do not override).

Ports:
clk_core  in  1  core clock.
reset  in  1  synchronous, active-high reset.
miss_req  in  1  fetch requests refill of the line containing miss_paddr.
miss_paddr  in  27  [28:2] physical word address of the missed fetch.
miss_ready  out  1  engine idle and able to accept miss_req.
flush  in  1  abandon the current refill (e.g. fence.i / redirect).
bus_req  out  1  burst read command valid.
bus_addr  out  27  [28:2] line-aligned burst start address.
bus_len  out  5  beat count, equals LINE_WORDS.
bus_ack  in  1  command accepted this cycle.
bus_rvalid  in  1  read beat valid.
bus_rdata  in  32  read beat data.
bus_rerr  in  1  beat carries a bus error.
cam_write_index  out  10  [11:2] CAM word index.
cam_write_req_data  out  1  write cam_write_data.
cam_write_data  out  32  word to store.
cam_write_req_tag_flags  out  1  write tag and flags.
cam_write_tag  out  17  [28:12] physical tag.
cam_write_flags  out  2  bit0 valid, bit1 reserved (always 0).
fwd_valid  out  1  critical word available, one-cycle pulse.
fwd_data  out  32  critical word.
refill_done  out  1  one-cycle pulse, refill finished (any outcome).
refill_err  out  1  qualifies refill_done: bus error seen.

Behaviour:
- Reset, applied at the next clk_core edge regardless of state:
  - State to IDLE, beat counter 0, error flag 0.
  - All req/valid/pulse outputs 0; miss_ready 1 in the cycle after reset.
  - Address/data outputs are don't-care but driven 0.
- IDLE:
  - miss_ready=1.
  - On miss_req, latch line = miss_paddr[28:2+OFF_W] and crit = miss_paddr[2+OFF_W-1:2]; go to REQ.
  - flush in IDLE is ignored.
- REQ:
  - Drive bus_req=1, bus_addr={line, OFF_W'0}, bus_len=LINE_WORDS.
  - bus_addr and bus_len stay stable until bus_ack.
  - On bus_ack: go to FILL with beat=0.
  - flush while in REQ: go to IDLE next cycle only if bus_ack is not asserted that cycle; otherwise go to DRAIN.
- FILL, on each bus_rvalid beat:
  - Same cycle: cam_write_index={line[11:2+OFF_W], beat}.
  - cam_write_req_data=1, cam_write_req_tag_flags=1.
  - cam_write_data=bus_rdata, cam_write_tag=line address bits [28:12].
  - cam_write_flags = {1'b0, ~(bus_rerr | err_sticky)}.
  - A bus error sets err_sticky. The errored word and all later words are written invalid (flags 00).
  - If beat==crit and no error yet: fwd_valid=1, fwd_data=bus_rdata in the same cycle. fwd_valid is never raised for an errored critical word.
  - beat increments by 1. On the beat where beat==LINE_WORDS-1, go to DONE.
- DRAIN (entered by flush during FILL, or flush coinciding with bus_ack):
  - Consume the remaining beats up to LINE_WORDS total.
  - No CAM writes, no forwarding.
  - Then go to DONE.
- DONE:
  - Exactly one cycle.
  - refill_done=1, refill_err=err_sticky (0 if the refill was flushed before any error).
  - Clear err_sticky; go to IDLE. miss_ready=0 during DONE.
- Combinational CAM write: write outputs are asserted only in the cycle of the bus_rvalid beat. No extra latency; the CAM commits at the next edge.
- Latency, from miss_req accepted to refill_done with zero-wait bus: 1 (REQ) + ack + LINE_WORDS beats + 1 (DONE).
- flush arriving on the same beat as the final FILL beat: that beat is still written, and the state goes to DONE.
- bus_rvalid outside FILL/DRAIN is ignored (protocol violation, asserted in simulation).

Test Plan:
1. Basic refill, LINE_WORDS=4: miss_paddr=0x0000_1238>>2, bus_ack immediate, beats D0..D3 back-to-back.
   - Required: CAM indices 0x08C..0x08F, tag 0x00001, flags 01.
   - fwd_valid with D2 on the third beat; refill_done at 1 cycle after the last beat; refill_err=0.
2. Stalled ack: bus_ack delayed 5 cycles → bus_req held and bus_addr stable at 0x48C for all 5 cycles; no CAM writes before the first beat.
3. Error mid-line: bus_rerr on beat 1, crit=3 → beat 0 flags 01, beats 1–3 flags 00, no fwd_valid, refill_done with refill_err=1.
4. Flush in FILL after beat 1 → beats 2–3 consumed with no cam_write_req_*; refill_done=1, refill_err=0; miss_ready returns the next cycle.
5. Flush in REQ before ack → return to IDLE with no refill_done; flush coincident with bus_ack → DRAIN of 4 beats, then refill_done.
6. Reset asserted during FILL beat 2 → next cycle: all outputs 0, miss_ready=1; a new miss then completes normally.

Source files
------------

// File: rtl/icache_refill.sv
// icache_refill: instruction-cache miss/refill engine.
// Issues one line-aligned burst read per miss and writes every returned beat into the CAM.
// The critical word is forwarded to fetch as it streams past.
// Completion, with an error qualifier, is reported back to fetch.
module icache_refill #(
    parameter int unsigned    LINE_WORDS = 4,
    localparam int unsigned   OFF_W      = $clog2(LINE_WORDS)
) (
    input  logic              clk_core,
    input  logic              reset,
    input  logic              miss_req,
    input  logic [26:0]       miss_paddr,
    output logic              miss_ready,
    input  logic              flush,
    output logic              bus_req,
    output logic [26:0]       bus_addr,
    output logic [4:0]        bus_len,
    input  logic              bus_ack,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_rerr,
    output logic [9:0]        cam_write_index,
    output logic              cam_write_req_data,
    output logic [31:0]       cam_write_data,
    output logic              cam_write_req_tag_flags,
    output logic [16:0]       cam_write_tag,
    output logic [1:0]        cam_write_flags,
    output logic              fwd_valid,
    output logic [31:0]       fwd_data,
    output logic              refill_done,
    output logic              refill_err
);

    localparam int unsigned LINE_W = 27 - OFF_W;
    localparam logic [OFF_W-1:0] LastBeat = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StFill,
        StDrain,
        StDone
    } state_e;

    state_e              r_state;
    logic [LINE_W-1:0]   r_line;
    logic [OFF_W-1:0]    r_crit;
    logic [OFF_W-1:0]    r_beat;
    logic                r_err;

    logic [26:0]         w_waddr;
    logic                w_wr;
    logic                w_beat_bad;

    assign w_waddr    = {r_line, r_beat};
    assign w_wr       = (r_state == StFill) && bus_rvalid;
    // A beat is invalid if it errors itself or any earlier beat of this line did.
    assign w_beat_bad = bus_rerr || r_err;

    // Refill sequencing: latch the miss, hand off the burst, count beats, report once.
    always_ff @(posedge clk_core) begin
        if (reset) begin
            r_state <= StIdle;
            r_line  <= '0;
            r_crit  <= '0;
            r_beat  <= '0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (miss_req) begin
                        r_line  <= miss_paddr[26:OFF_W];
                        r_crit  <= miss_paddr[OFF_W-1:0];
                        r_state <= StReq;
                    end
                end
                StReq: begin
                    if (bus_ack) begin
                        // Once the command is accepted the beats will come; flush must drain them.
                        r_beat  <= '0;
                        r_state <= flush ? StDrain : StFill;
                    end else if (flush) begin
                        r_state <= StIdle;
                    end
                end
                StFill: begin
                    if (bus_rvalid) begin
                        r_beat <= r_beat + OFF_W'(1);
                        if (bus_rerr) begin
                            r_err <= 1'b1;
                        end
                        if (r_beat == LastBeat) begin
                            r_state <= StDone;
                        end else if (flush) begin
                            r_state <= StDrain;
                        end
                    end else if (flush) begin
                        r_state <= StDrain;
                    end
                end
                StDrain: begin
                    if (bus_rvalid) begin
                        r_beat <= r_beat + OFF_W'(1);
                        if (r_beat == LastBeat) begin
                            r_state <= StDone;
                        end
                    end
                end
                StDone: begin
                    r_err   <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Outputs: state decodes plus the same-cycle CAM write and critical-word bypass.
    always_comb begin
        miss_ready              = (r_state == StIdle);
        bus_req                 = (r_state == StReq);
        bus_addr                = '0;
        bus_len                 = '0;
        if (r_state == StReq) begin
            bus_addr = {r_line, {OFF_W{1'b0}}};
            bus_len  = 5'(LINE_WORDS);
        end
        cam_write_req_data      = w_wr;
        cam_write_req_tag_flags = w_wr;
        cam_write_index         = '0;
        cam_write_data          = '0;
        cam_write_tag           = '0;
        cam_write_flags         = '0;
        if (w_wr) begin
            cam_write_index = w_waddr[9:0];
            cam_write_data  = bus_rdata;
            cam_write_tag   = w_waddr[26:10];
            cam_write_flags = {1'b0, ~w_beat_bad};
        end
        fwd_valid               = w_wr && (r_beat == r_crit) && !w_beat_bad;
        fwd_data                = fwd_valid ? bus_rdata : '0;
        refill_done             = (r_state == StDone);
        refill_err              = (r_state == StDone) && r_err;
    end

    // Read beats are only legal while a burst is outstanding.
    assert property (@(posedge clk_core) disable iff (reset)
        bus_rvalid |-> (r_state == StFill || r_state == StDrain));

endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: directed bench for icache_refill with LINE_WORDS=4.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_icache_refill;

    logic        clk_core = 1'b0;
    logic        reset;
    logic        miss_req;
    logic [26:0] miss_paddr;
    logic        miss_ready;
    logic        flush;
    logic        bus_req;
    logic [26:0] bus_addr;
    logic [4:0]  bus_len;
    logic        bus_ack;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_rerr;
    logic [9:0]  cam_write_index;
    logic        cam_write_req_data;
    logic [31:0] cam_write_data;
    logic        cam_write_req_tag_flags;
    logic [16:0] cam_write_tag;
    logic [1:0]  cam_write_flags;
    logic        fwd_valid;
    logic [31:0] fwd_data;
    logic        refill_done;
    logic        refill_err;

    int n_vec = 0;
    int n_err = 0;

    icache_refill #(.LINE_WORDS(4)) dut (
        .clk_core                (clk_core),
        .reset                   (reset),
        .miss_req                (miss_req),
        .miss_paddr              (miss_paddr),
        .miss_ready              (miss_ready),
        .flush                   (flush),
        .bus_req                 (bus_req),
        .bus_addr                (bus_addr),
        .bus_len                 (bus_len),
        .bus_ack                 (bus_ack),
        .bus_rvalid              (bus_rvalid),
        .bus_rdata               (bus_rdata),
        .bus_rerr                (bus_rerr),
        .cam_write_index         (cam_write_index),
        .cam_write_req_data      (cam_write_req_data),
        .cam_write_data          (cam_write_data),
        .cam_write_req_tag_flags (cam_write_req_tag_flags),
        .cam_write_tag           (cam_write_tag),
        .cam_write_flags         (cam_write_flags),
        .fwd_valid               (fwd_valid),
        .fwd_data                (fwd_data),
        .refill_done             (refill_done),
        .refill_err              (refill_err)
    );

    always #5 clk_core = ~clk_core;

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a miss in IDLE; returns with the DUT in REQ.
    task automatic start_miss(input logic [26:0] pa);
        miss_req   = 1'b1;
        miss_paddr = pa;
        #1;
        chk("miss_ready_idle", {31'd0, miss_ready}, 32'd1);
        tick();
        miss_req = 1'b0;
    endtask

    // One beat in FILL that must be written to the CAM.
    task automatic beat_wr(input logic [31:0] d, input logic err_in, input logic [9:0] idx,
                           input logic [16:0] tag, input logic [1:0] flags, input logic fwd);
        bus_rvalid = 1'b1;
        bus_rdata  = d;
        bus_rerr   = err_in;
        #1;
        chk("wr_req_data", {31'd0, cam_write_req_data}, 32'd1);
        chk("wr_req_tagflags", {31'd0, cam_write_req_tag_flags}, 32'd1);
        chk("wr_index", {22'd0, cam_write_index}, {22'd0, idx});
        chk("wr_data", cam_write_data, d);
        chk("wr_tag", {15'd0, cam_write_tag}, {15'd0, tag});
        chk("wr_flags", {30'd0, cam_write_flags}, {30'd0, flags});
        chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, fwd});
        if (fwd) begin
            chk("fwd_data", fwd_data, d);
        end
        tick();
        bus_rvalid = 1'b0;
        bus_rerr   = 1'b0;
    endtask

    // One beat that must be swallowed without CAM writes or forwarding.
    task automatic beat_drain(input logic [31:0] d);
        bus_rvalid = 1'b1;
        bus_rdata  = d;
        #1;
        chk("drain_req_data", {31'd0, cam_write_req_data}, 32'd0);
        chk("drain_req_tagflags", {31'd0, cam_write_req_tag_flags}, 32'd0);
        chk("drain_fwd", {31'd0, fwd_valid}, 32'd0);
        chk("drain_done", {31'd0, refill_done}, 32'd0);
        tick();
        bus_rvalid = 1'b0;
    endtask

    // Expect the DONE cycle now, then IDLE.
    task automatic expect_done(input logic err_exp);
        #1;
        chk("done", {31'd0, refill_done}, 32'd1);
        chk("done_err", {31'd0, refill_err}, {31'd0, err_exp});
        chk("done_not_ready", {31'd0, miss_ready}, 32'd0);
        tick();
        chk("done_pulse_end", {31'd0, refill_done}, 32'd0);
        chk("ready_after_done", {31'd0, miss_ready}, 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        miss_req   = 1'b0;
        miss_paddr = '0;
        flush      = 1'b0;
        bus_ack    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        bus_rerr   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_ready", {31'd0, miss_ready}, 32'd1);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_done", {31'd0, refill_done}, 32'd0);
        chk("rst_wr", {31'd0, cam_write_req_data}, 32'd0);
        chk("rst_fwd", {31'd0, fwd_valid}, 32'd0);

        // 1: basic refill, 0x1238 byte address -> line 0x48C, crit 2.
        start_miss(27'h48E);
        chk("req_bus_req", {31'd0, bus_req}, 32'd1);
        chk("req_addr", {5'd0, bus_addr}, 32'h48C);
        chk("req_len", {27'd0, bus_len}, 32'd4);
        chk("req_not_ready", {31'd0, miss_ready}, 32'd0);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        for (int b = 0; b < 4; b++) begin
            beat_wr(32'hD000_0000 + b, 1'b0, 10'h08C + 10'(b), 17'h1, 2'b01, b == 2);
        end
        expect_done(1'b0);

        // 2: ack stalled 5 cycles; command must stay put and nothing is written.
        start_miss(27'h48E);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_req", {31'd0, bus_req}, 32'd1);
            chk("stall_addr", {5'd0, bus_addr}, 32'h48C);
            chk("stall_no_wr", {31'd0, cam_write_req_data}, 32'd0);
            tick();
        end
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        for (int b = 0; b < 4; b++) begin
            beat_wr(32'h5000_0000 + b, 1'b0, 10'h08C + 10'(b), 17'h1, 2'b01, b == 2);
        end
        expect_done(1'b0);

        // 3: error on beat 1 with crit 3; beats 1..3 invalid, no forward.
        start_miss(27'h48F);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        for (int b = 0; b < 4; b++) begin
            beat_wr(32'hE000_0000 + b, b == 1, 10'h08C + 10'(b), 17'h1,
                    (b == 0) ? 2'b01 : 2'b00, 1'b0);
        end
        expect_done(1'b1);

        // 4: flush in FILL after beat 1; remaining beats drained.
        start_miss(27'h48E);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        beat_wr(32'hF000_0000, 1'b0, 10'h08C, 17'h1, 2'b01, 1'b0);
        beat_wr(32'hF000_0001, 1'b0, 10'h08D, 17'h1, 2'b01, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        beat_drain(32'hF000_0002);
        beat_drain(32'hF000_0003);
        expect_done(1'b0);

        // 5a: flush in REQ before ack -> back to IDLE, no done pulse.
        start_miss(27'h48E);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("flushreq_ready", {31'd0, miss_ready}, 32'd1);
        chk("flushreq_bus_req", {31'd0, bus_req}, 32'd0);
        chk("flushreq_done", {31'd0, refill_done}, 32'd0);
        tick();
        chk("flushreq_done2", {31'd0, refill_done}, 32'd0);

        // 5b: flush coincident with ack -> drain all 4 beats, then done.
        start_miss(27'h48E);
        flush   = 1'b1;
        bus_ack = 1'b1;
        tick();
        flush   = 1'b0;
        bus_ack = 1'b0;
        for (int b = 0; b < 4; b++) begin
            beat_drain(32'hC000_0000 + b);
        end
        expect_done(1'b0);

        // 6: reset during beat 2, then a fresh miss with flush on its final beat.
        start_miss(27'h48E);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        beat_wr(32'hA000_0000, 1'b0, 10'h08C, 17'h1, 2'b01, 1'b0);
        beat_wr(32'hA000_0001, 1'b0, 10'h08D, 17'h1, 2'b01, 1'b0);
        reset      = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hA000_0002;
        tick();
        reset      = 1'b0;
        bus_rvalid = 1'b0;
        #1;
        chk("rst2_ready", {31'd0, miss_ready}, 32'd1);
        chk("rst2_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst2_bus_addr", {5'd0, bus_addr}, 32'd0);
        chk("rst2_bus_len", {27'd0, bus_len}, 32'd0);
        chk("rst2_wr", {31'd0, cam_write_req_data}, 32'd0);
        chk("rst2_wr_tf", {31'd0, cam_write_req_tag_flags}, 32'd0);
        chk("rst2_index", {22'd0, cam_write_index}, 32'd0);
        chk("rst2_fwd", {31'd0, fwd_valid}, 32'd0);
        chk("rst2_done", {31'd0, refill_done}, 32'd0);
        chk("rst2_err", {31'd0, refill_err}, 32'd0);
        start_miss(27'h123);
        chk("rst2_req_addr", {5'd0, bus_addr}, 32'h120);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        for (int b = 0; b < 3; b++) begin
            beat_wr(32'hB000_0000 + b, 1'b0, 10'h120 + 10'(b), 17'h0, 2'b01, 1'b0);
        end
        flush = 1'b1;
        beat_wr(32'hB000_0003, 1'b0, 10'h123, 17'h0, 2'b01, 1'b1);
        flush = 1'b0;
        expect_done(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
